// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: IF/ID payload layout, its bubble value and
// the occupancy encoding used by pipe_stage_skid.
package pipe_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_plus_4;
    logic [31:0] instr;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{pc: 32'h0, pc_plus_4: 32'h0, instr: NOP_INSTR};

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

  function automatic logic [1:0] occ_of(input logic out_v, input logic skid_v);
    return {1'b0, out_v} + {1'b0, skid_v};
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One payload register with a valid bit. Clearing always reloads the bubble
// value so an empty slot never shows stale data.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int                 DATA_W     = 96,
  parameter logic [DATA_W-1:0]  BUBBLE_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] d,
  output logic              valid,
  output logic [DATA_W-1:0] q
);

  logic              valid_reg;
  logic [DATA_W-1:0] data_reg;

  // clear wins over load so a flush cannot be overridden by a same-cycle load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= 1'b0;
      data_reg  <= BUBBLE_VAL;
    end else if (clear) begin
      valid_reg <= 1'b0;
      data_reg  <= BUBBLE_VAL;
    end else if (load) begin
      valid_reg <= 1'b1;
      data_reg  <= d;
    end
  end

  assign valid = valid_reg;
  assign q     = data_reg;

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready on both sides, flush, and an
// optional skid slot that makes in_ready a plain flop output.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int                DATA_W     = 96,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
  parameter int                SKID       = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        count
);

  logic              accept;
  logic              drain;
  logic              out_load;
  logic              out_clear;
  logic              skid_load;
  logic              skid_clear;
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [DATA_W-1:0] out_d;
  logic              out_valid_next;
  logic              skid_valid_next;
  logic [1:0]        count_reg;
  logic [1:0]        count_next;

  assign accept = in_valid && in_ready;
  assign drain  = out_valid && out_ready;

  // count_reg doubles as the occupancy state
  always_comb begin
    out_load   = 1'b0;
    out_clear  = 1'b0;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    out_d      = in_data;
    if (flush) begin
      out_clear  = 1'b1;
      skid_clear = 1'b1;
    end else begin
      case (count_reg)
        OCC_EMPTY: out_load = accept;
        OCC_ONE: begin
          if (drain) begin
            out_load  = accept;
            out_clear = !accept;
          end else begin
            skid_load = accept && (SKID != 0);
          end
        end
        OCC_FULL: begin
          if (drain) begin
            out_load   = 1'b1;
            out_d      = skid_data;
            skid_clear = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid_next  = out_clear  ? 1'b0 : (out_load  ? 1'b1 : out_valid);
  assign skid_valid_next = skid_clear ? 1'b0 : (skid_load ? 1'b1 : skid_valid);
  assign count_next      = occ_of(out_valid_next, skid_valid_next);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_reg <= OCC_EMPTY;
    else     count_reg <= count_next;
  end

  assign count = count_reg;

  pipe_slot #(
    .DATA_W     (DATA_W),
    .BUBBLE_VAL (BUBBLE_VAL)
  ) u_out_slot (
    .clk   (clk),
    .rst   (rst),
    .load  (out_load),
    .clear (out_clear),
    .d     (out_d),
    .valid (out_valid),
    .q     (out_data)
  );

  generate
    if (SKID != 0) begin : g_skid
      logic in_ready_reg;

      pipe_slot #(
        .DATA_W     (DATA_W),
        .BUBBLE_VAL (BUBBLE_VAL)
      ) u_skid_slot (
        .clk   (clk),
        .rst   (rst),
        .load  (skid_load),
        .clear (skid_clear),
        .d     (in_data),
        .valid (skid_valid),
        .q     (skid_data)
      );

      // registered copy of "skid slot free", no path from out_ready
      always_ff @(posedge clk or posedge rst) begin
        if (rst) in_ready_reg <= 1'b1;
        else     in_ready_reg <= !skid_valid_next;
      end

      assign in_ready = in_ready_reg;
    end else begin : g_noskid
      assign skid_valid = 1'b0;
      assign skid_data  = BUBBLE_VAL;
      assign in_ready   = !out_valid || out_ready;
    end
  endgenerate

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline stage register with a valid/ready handshake on both sides, synchronous flush and bubble injection. It replaces the fixed enable/clear stage registers between IF/ID, ID/EX, EX/MEM and MEM/WB. An optional 2-entry skid buffer makes upstream `in_ready` a pure register output, which breaks the stall path across stages.

## Interface
Parameters:
- `DATA_W`, 96, payload width (IF/ID: pc, pc_plus_4, instr).
- `BUBBLE_VAL`, `'0`, value driven on `out_data` whenever `out_valid`=0.
- `SKID`, 1, 1 = 2-entry skid buffer with registered `in_ready`; 0 = single register with combinational `in_ready`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `flush`  in  1  synchronous clear of all held entries; replaces `clr`.
- `in_valid`  in  1  upstream entry present.
- `in_ready`  out  1  stage can accept this cycle.
- `in_data`  in  DATA_W  upstream payload.
- `out_valid`  out  1  `out_data` holds a live entry.
- `out_ready`  in  1  downstream consumes this cycle.
- `out_data`  out  DATA_W  registered payload.
- `count`  out  2  entries held (0..2; max 1 when `SKID`=0).

## Operation
- Accept when `in_valid && in_ready`. Drain when `out_valid && out_ready`.
- State is the pair {out slot, skid slot}. Occupancy states are EMPTY (0), ONE (1) and FULL (2, `SKID`=1 only).
- EMPTY:
  - accept → ONE, with the input loaded into the out slot.
- ONE:
  - accept and drain → ONE, out slot reloaded.
  - drain only → EMPTY.
  - accept only → FULL (input into skid slot; only when `SKID`=1).
  - neither → hold.
- FULL:
  - drain → ONE, skid slot moves to out slot.
  - `in_ready`=0, so there is no accept.
- `SKID`=1: `in_ready` = !skid_valid, registered.
- `SKID`=0: `in_ready` = !out_valid || out_ready. The FULL state is unreachable.
- `flush` has priority over accept and drain:
  - next state EMPTY, `out_data`=BUBBLE_VAL.
  - Any entry accepted in the flush cycle is discarded.
  - The drain handshake in that cycle still counts as consumed downstream.
- Whenever the out slot is empty, `out_data` is loaded with BUBBLE_VAL, never stale data.
- Ordering is strictly FIFO. No entry is ever duplicated or dropped except by `flush`.
- Stall (enable=0 in the old style) is expressed by driving `out_ready`=0.

## Timing
- Reset values:
  - `out_valid`=0, `out_data`=BUBBLE_VAL, `count`=0.
  - `in_ready`=1 (both modes, since the stage is empty).
  - skid slot invalid.
- Latency is 1 cycle from accept to `out_valid`. Throughput is 1 entry/cycle in steady state in both modes.
- `SKID`=1 timing:
  - `in_ready` falls in the cycle after the entry that fills the skid slot.
  - It rises in the cycle after that slot drains.
  - `in_ready` has no combinational dependence on `out_ready`.
- `flush`: takes effect at the next edge; `in_ready`=1 from the following cycle.
- Reset asserted mid-transfer: all state clears immediately (asynchronous); no handshake completes.
- `count` is registered and updates in the same edge as the slots.

## Structure
- Shared package `pipe_pkg`:
  - `NOP_INSTR` = 32'h0000_0013.
  - packed struct `if_id_t` {pc, pc_plus_4, instr}, 96 bits.
  - Bubble constant `IF_ID_BUBBLE` (pc 0, pc_plus_4 0, instr NOP).
- Sub-module `pipe_slot`: one data+valid register with load/clear/bubble. Instantiated once for the out slot, plus once for the skid slot when `SKID`=1.

## Test plan
- Reset with `SKID`=1, `BUBBLE_VAL`=IF_ID_BUBBLE:
  - `out_valid`=0, `out_data` instr=32'h13, `in_ready`=1, `count`=0.
- Streaming: send 0x1..0x8 back-to-back with `out_ready`=1.
  - Outputs appear 0x1..0x8 one cycle after each accept, no gaps.
- Backpressure (`SKID`=1): drop `out_ready` while streaming.
  - Holds 2 entries, `count`=2, `in_ready`=0 the following cycle.
  - On release, order is preserved and no loss occurs.
- Flush while FULL, with `in_valid`=1 in the same cycle:
  - next cycle `count`=0, `out_valid`=0, `out_data`=bubble.
  - The flushed-cycle input never appears.
- `SKID`=0 under random `in_valid`/`out_ready`:
  - `in_ready` == !out_valid||out_ready every cycle.
  - Scoreboard shows the output sequence equals the accepted sequence.
- Assert `rst` asynchronously mid-stream (between edges):
  - outputs return to reset values immediately.
  - The stream restarts cleanly after release.
